ritc_capture_buffer: RTL and testbench
======================================

// Module: ritc_capture_buffer
// PURPOSE
// - Pretrigger/posttrigger snapshot memory for the six reordered 48-bit RITC channel words (16 x 3-bit samples each).
// - Sits directly downstream of the dual-RITC datapath, on its SYSCLK channel outputs and buffer-valid flag.
// - On trigger, freezes DEPTH words of all channels around the trigger; readout is a random-access read port in the same clock domain.
// PARAMETERS
// - ADDR_W   9   log2 of buffer depth; DEPTH = 2**ADDR_W words of 288 bits.
// - PRETRIG  64  words kept before the trigger word, 1..DEPTH-1.
// PORTS
// - SYSCLK       in   1    sole clock, 162.5 MHz.
// - rst_n_i      in   1    asynchronous, active-low reset.
// - dat_i        in   288  {ch5,...,ch0}, each 48 bits.
// - valid_i      in   1    dat_i valid (datapath buffer valid).
// - arm_i        in   1    single-cycle pulse: start a capture.
// - trig_i       in   1    single-cycle pulse: trigger.
// - state_o      out  2    0=IDLE, 1=FILL, 2=ARMED, 3=POST; DONE is IDLE with done_o=1.
// - done_o       out  1    capture complete, buffer frozen.
// - start_addr_o out  ADDR_W  physical address of the oldest captured word.
// - rd_addr_i    in   ADDR_W  read offset relative to the oldest word.
// - rd_ch_i      in   3    channel select, 0..5; 6 and 7 read zero.
// - rd_dat_o     out  48   read data.
// - ts_o         out  32   trigger timestamp; present only with the macro.
// BEHAVIOUR
// - Reset values: state IDLE; done_o=0; start_addr_o=0; rd_dat_o=0; ts_o=0; write pointer and counters 0. RAM contents undefined.
// - Writes occur only in FILL, ARMED and POST, and only when valid_i=1.
//   - Write address is wptr. wptr increments modulo DEPTH after each write and wraps silently.
//   - When valid_i=0, no write occurs and all counters hold.
// - IDLE:
//   - arm_i -> FILL. done_o clears, and the fill counter clears.
//   - trig_i is ignored.
// - FILL:
//   - Counts valid writes. On the PRETRIG-th write -> ARMED.
//   - trig_i in FILL is ignored and not queued.
// - ARMED:
//   - trig_i -> POST. The trigger-cycle word is written if valid_i=1.
//   - start_addr_o <= tptr - PRETRIG mod DEPTH, where tptr is wptr at the trigger cycle.
//   - The post counter loads DEPTH-PRETRIG, counting the trigger word.
// - POST:
//   - The post counter decrements per valid write.
//   - The write that brings it to 0 -> IDLE with done_o=1 on the next cycle.
//   - Exactly DEPTH words are retained: PRETRIG before the trigger, DEPTH-PRETRIG from the trigger word on.
// - arm_i in FILL, ARMED or POST is ignored.
// - arm_i while done_o=1 starts a new capture; done_o drops the cycle after arm_i.
// - arm_i and trig_i in the same IDLE cycle: arm is taken, trig is dropped.
// - If the trigger cycle has valid_i=0, the trigger is still accepted and the next valid word counts as the trigger word.
// - Read path:
//   - Physical address = start_addr_o + rd_addr_i mod DEPTH.
//   - 2-cycle latency: RAM output register, then channel-mux register.
//   - Reads are legal in any state; during capture they return live or stale data, with no hazard protection.
// - Async reset mid-capture aborts the capture to IDLE with done_o=0.
// CONFIGURATION
// - RITC_CAPTURE_TIMESTAMP_EN defined:
//   - A 32-bit free-running counter increments every SYSCLK and wraps at 2**32.
//   - ts_o latches the counter at the accepted trigger cycle and holds until the next accepted trigger.
// - RITC_CAPTURE_TIMESTAMP_EN undefined:
//   - The ts_o port is absent and there is no counter logic.
// TESTING
// - Reset, arm, valid_i=1 held, dat_i = counter word k:
//   - state_o steps FILL, then ARMED after 64 cycles.
//   - trig at k=100 -> done_o after 448 more writes (k=99+448=547).
//   - rd_addr_i 0..511 returns k=36..547; rd_addr 64 returns k=100 on rd_dat_o 2 cycles later.
// - Trigger in FILL at write 10 is ignored: state stays FILL, done_o=0.
//   - A second trig after 64 writes completes normally.
// - valid_i toggling 1-0 during POST: done_o is asserted only after 448 valid writes.
//   - The captured sequence is contiguous, with no holes.
// - Wrap: 3 captures back to back with different trigger times.
//   - start_addr_o = (tptr-64) mod 512 each time, including a case with tptr<64.
// - rst_n_i asserted during POST:
//   - All outputs return to reset values asynchronously.
//   - A fresh arm/trig then captures correctly.
// - With RITC_CAPTURE_TIMESTAMP_EN, trig at cycle 1000 after reset: ts_o=1000 (±1 per the defined counter origin) and holds through readout.

Source files
------------

// File: rtl/ritc_capture_buffer_if.sv
// ---------------------------------------------------------------------------
// ritc_capture_buffer_if
//
// Purpose:
//   Bundles the capture-buffer data, control and read-port signals. The
//   datapath/controller side drives the inputs and the buffer drives the
//   outputs. Signal names carry the direction as seen from the buffer.
//
// Signals (buffer view):
//   dat_i        in   288     {ch5,...,ch0}, 48 bits per channel
//   valid_i      in   1       dat_i valid
//   arm_i        in   1       single-cycle pulse: start a capture
//   trig_i       in   1       single-cycle pulse: trigger
//   state_o      out  2       0=IDLE 1=FILL 2=ARMED 3=POST
//   done_o       out  1       capture complete, buffer frozen
//   start_addr_o out  ADDR_W  physical address of the oldest captured word
//   rd_addr_i    in   ADDR_W  read offset relative to the oldest word
//   rd_ch_i      in   3       channel select (6 and 7 read zero)
//   rd_dat_o     out  48      read data
//   ts_o         out  32      trigger timestamp (RITC_CAPTURE_TIMESTAMP_EN only)
//
// Build option: RITC_CAPTURE_TIMESTAMP_EN adds the ts_o signal.
// ---------------------------------------------------------------------------
interface ritc_capture_buffer_if #(
  parameter int ADDR_W = 9
) ();

  logic [287:0]       dat_i;
  logic               valid_i;
  logic               arm_i;
  logic               trig_i;
  logic [1:0]         state_o;
  logic               done_o;
  logic [ADDR_W-1:0]  start_addr_o;
  logic [ADDR_W-1:0]  rd_addr_i;
  logic [2:0]         rd_ch_i;
  logic [47:0]        rd_dat_o;
`ifdef RITC_CAPTURE_TIMESTAMP_EN
  logic [31:0]        ts_o;
`endif

  // Upstream / readout controller side
  modport master (
    output dat_i, valid_i, arm_i, trig_i, rd_addr_i, rd_ch_i,
    input  state_o, done_o, start_addr_o, rd_dat_o
`ifdef RITC_CAPTURE_TIMESTAMP_EN
    , input ts_o
`endif
  );

  // Capture buffer side
  modport slave (
    input  dat_i, valid_i, arm_i, trig_i, rd_addr_i, rd_ch_i,
    output state_o, done_o, start_addr_o, rd_dat_o
`ifdef RITC_CAPTURE_TIMESTAMP_EN
    , output ts_o
`endif
  );

endinterface

// File: rtl/ritc_capture_buffer.sv
// ---------------------------------------------------------------------------
// ritc_capture_buffer
//
// Purpose:
//   Pretrigger/posttrigger snapshot memory for the six reordered 48-bit RITC
//   channel words. While a capture runs, every valid 288-bit word is written
//   into a circular buffer of DEPTH = 2**ADDR_W words. After arm, PRETRIG
//   words are collected (FILL), then the buffer waits for a trigger (ARMED).
//   From the trigger word on, DEPTH-PRETRIG further words are stored (POST),
//   after which the buffer freezes and done_o is raised. The frozen window is
//   read through a random-access port addressed relative to the oldest word.
//
// Ports:
//   SYSCLK   in  sole clock
//   rst_n_i  in  asynchronous active-low reset
//   bus      ritc_capture_buffer_if.slave (data, arm/trig, status, read port)
//
// Parameters:
//   ADDR_W   log2 of buffer depth
//   PRETRIG  words kept before the trigger word, 1..DEPTH-1
//
// Build option:
//   RITC_CAPTURE_TIMESTAMP_EN  adds a free-running 32-bit cycle counter that
//                              is latched onto bus.ts_o at each accepted
//                              trigger.
// ---------------------------------------------------------------------------
module ritc_capture_buffer #(
  parameter int ADDR_W  = 9,
  parameter int PRETRIG = 64
) (
  input  logic                   SYSCLK,
  input  logic                   rst_n_i,
  ritc_capture_buffer_if.slave   bus
);

  localparam int DEPTH   = 1 << ADDR_W;
  localparam int CH_W    = 48;
  localparam int N_CH    = 6;
  localparam int CNT_W   = ADDR_W + 1;

  localparam logic [CNT_W-1:0]  CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0]  FILL_LAST    = CNT_W'(PRETRIG - 1);
  localparam logic [CNT_W-1:0]  POST_LOAD    = CNT_W'(DEPTH - PRETRIG);
  localparam logic [CNT_W-1:0]  POST_LOAD_M1 = CNT_W'(DEPTH - PRETRIG - 1);
  localparam logic [ADDR_W-1:0] PRE_OFS      = ADDR_W'(PRETRIG);
  localparam logic [ADDR_W-1:0] PTR_ONE      = ADDR_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_ARMED = 2'd2,
    ST_POST  = 2'd3
  } state_t;

  // -------------------------------------------------------------------------
  // Control state
  // -------------------------------------------------------------------------
  state_t              state_q;
  logic                done_q;
  logic [ADDR_W-1:0]   wptr_q;
  logic [ADDR_W-1:0]   start_addr_q;
  logic [CNT_W-1:0]    fill_cnt_q;
  logic [CNT_W-1:0]    post_cnt_q;

  logic                wr_en;
  logic                trig_accept;
  logic [CNT_W-1:0]    trig_post_cnt;

  // Writes happen in every capturing state, gated only by valid_i.
  assign wr_en       = bus.valid_i && (state_q != ST_IDLE);
  assign trig_accept = (state_q == ST_ARMED) && bus.trig_i;

  // The trigger-cycle word, when valid, is the first post-trigger word and
  // is already consumed from the post count on the trigger edge.
  assign trig_post_cnt = bus.valid_i ? POST_LOAD_M1 : POST_LOAD;

  always_ff @(posedge SYSCLK or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= ST_IDLE;
      done_q       <= 1'b0;
      wptr_q       <= '0;
      start_addr_q <= '0;
      fill_cnt_q   <= '0;
      post_cnt_q   <= '0;
    end else begin
      if (wr_en) begin
        wptr_q <= wptr_q + PTR_ONE;
      end

      case (state_q)
        ST_IDLE: begin
          // trig_i is ignored here, including when it coincides with arm_i.
          if (bus.arm_i) begin
            state_q    <= ST_FILL;
            done_q     <= 1'b0;
            fill_cnt_q <= '0;
          end
        end

        ST_FILL: begin
          // Triggers are neither accepted nor remembered until PRETRIG
          // words of history exist.
          if (bus.valid_i) begin
            fill_cnt_q <= fill_cnt_q + CNT_ONE;
            if (fill_cnt_q == FILL_LAST) begin
              state_q <= ST_ARMED;
            end
          end
        end

        ST_ARMED: begin
          if (bus.trig_i) begin
            // wptr_q is where the trigger word lands, whether it arrives
            // this cycle or on the next valid cycle.
            start_addr_q <= wptr_q - PRE_OFS;
            post_cnt_q   <= trig_post_cnt;
            if (trig_post_cnt == '0) begin
              state_q <= ST_IDLE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_POST;
            end
          end
        end

        ST_POST: begin
          if (bus.valid_i) begin
            post_cnt_q <= post_cnt_q - CNT_ONE;
            if (post_cnt_q == CNT_ONE) begin
              state_q <= ST_IDLE;
              done_q  <= 1'b1;
            end
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.state_o      = state_q;
  assign bus.done_o       = done_q;
  assign bus.start_addr_o = start_addr_q;

  // -------------------------------------------------------------------------
  // Snapshot memory: one write port at wptr, one registered read port.
  // No reset on the array or its output register so it maps onto block RAM.
  // -------------------------------------------------------------------------
  logic [N_CH*CH_W-1:0] mem [DEPTH];
  logic [N_CH*CH_W-1:0] ram_rd_q;
  logic [ADDR_W-1:0]    rd_phys;

  // Read offset is relative to the oldest captured word; wraps modulo DEPTH.
  assign rd_phys = start_addr_q + bus.rd_addr_i;

  always_ff @(posedge SYSCLK) begin
    if (wr_en) begin
      mem[wptr_q] <= bus.dat_i;
    end
    ram_rd_q <= mem[rd_phys];
  end

  // -------------------------------------------------------------------------
  // Channel mux, second read stage. The channel select is delayed one cycle
  // so it stays aligned with the address that produced ram_rd_q.
  // -------------------------------------------------------------------------
  logic [2:0]       rd_ch_q;
  logic [CH_W-1:0]  rd_dat_q;
  logic [CH_W-1:0]  ch_word [8];

  for (genvar gi = 0; gi < 8; gi++) begin : g_ch_word
    if (gi < N_CH) begin : g_live
      assign ch_word[gi] = ram_rd_q[gi*CH_W +: CH_W];
    end else begin : g_zero
      assign ch_word[gi] = '0;
    end
  end

  always_ff @(posedge SYSCLK or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_ch_q  <= '0;
      rd_dat_q <= '0;
    end else begin
      rd_ch_q  <= bus.rd_ch_i;
      rd_dat_q <= ch_word[rd_ch_q];
    end
  end

  assign bus.rd_dat_o = rd_dat_q;

  // -------------------------------------------------------------------------
  // Optional trigger timestamp
  // -------------------------------------------------------------------------
`ifdef RITC_CAPTURE_TIMESTAMP_EN
  logic [31:0] ts_cnt_q;
  logic [31:0] ts_q;

  // ts_cnt_q counts SYSCLK edges since reset release; the value latched is
  // the count held before the trigger edge.
  always_ff @(posedge SYSCLK or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ts_cnt_q <= '0;
      ts_q     <= '0;
    end else begin
      ts_cnt_q <= ts_cnt_q + 32'd1;
      if (trig_accept) begin
        ts_q <= ts_cnt_q;
      end
    end
  end

  assign bus.ts_o = ts_q;
`else
  // trig_accept only feeds the timestamp latch.
  logic unused_trig_accept;
  assign unused_trig_accept = trig_accept;
`endif

endmodule

// File: tb/tb_ritc_capture_buffer.sv
module tb_ritc_capture_buffer;

  localparam int ADDR_W  = 9;
  localparam int DEPTH   = 512;
  localparam int PRETRIG = 64;

  logic SYSCLK;
  logic rst_n;

  always begin
    SYSCLK = 1'b0;
    #5;
    SYSCLK = 1'b1;
    #5;
  end

  ritc_capture_buffer_if #(.ADDR_W(ADDR_W)) bus ();

  ritc_capture_buffer #(
    .ADDR_W  (ADDR_W),
    .PRETRIG (PRETRIG)
  ) dut (
    .SYSCLK  (SYSCLK),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  int n_checks;
  int n_fail;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // -------------------------------------------------------------------------
  // Behavioural model: a history of every word written since reset, indexed
  // by write number. The physical address of write n is n mod DEPTH, so the
  // frozen window is simply history[trig_idx-PRETRIG .. trig_idx+DEPTH-PRETRIG-1].
  // -------------------------------------------------------------------------
  logic [287:0] hist [int];
  int           n_wr;
  bit           m_active;
  bit           m_done;
  bit           m_trig_seen;
  int           m_fill;
  int           m_trig_idx;
  logic [ADDR_W-1:0] m_start;
  int           edges;
  logic [31:0]  m_ts;
  bit           p1_v, p2_v;
  logic [47:0]  p1_d, p2_d;

  function automatic logic [47:0] cap_word(input int r, input int ch);
    logic [287:0] w;
    int idx;
    if (ch > 5) return 48'h0;
    idx = m_trig_idx - PRETRIG + r;
    if (!hist.exists(idx)) return 48'hdead_dead_dead;
    w = hist[idx];
    return w[ch*48 +: 48];
  endfunction

  function automatic logic [1:0] m_state();
    if (!m_active) return 2'd0;
    if (m_fill < PRETRIG) return 2'd1;
    if (!m_trig_seen) return 2'd2;
    return 2'd3;
  endfunction

  task automatic model_reset();
    hist.delete();
    n_wr = 0; m_active = 0; m_done = 0; m_trig_seen = 0; m_fill = 0;
    m_trig_idx = 0; m_start = '0; edges = 0; m_ts = '0;
    p1_v = 0; p2_v = 0; p1_d = '0; p2_d = '0;
  endtask

  // Applies the inputs the DUT saw on this rising edge.
  task automatic model_update();
    p2_v = p1_v;
    p2_d = p1_d;
    p1_v = m_done;
    if (p1_v) p1_d = cap_word(int'(bus.rd_addr_i), int'(bus.rd_ch_i));
    if (!m_active) begin
      if (bus.arm_i) begin
        m_active = 1; m_done = 0; m_fill = 0; m_trig_seen = 0;
      end
    end else begin
      if (m_fill < PRETRIG) begin
        if (bus.valid_i) m_fill++;
      end else if (!m_trig_seen && bus.trig_i) begin
        m_trig_seen = 1;
        m_trig_idx  = n_wr;
        m_start     = ADDR_W'((n_wr - PRETRIG) & (DEPTH - 1));
        m_ts        = 32'(edges);
      end
      if (bus.valid_i) begin
        hist[n_wr] = bus.dat_i;
        n_wr++;
      end
      if (m_trig_seen && n_wr == m_trig_idx + DEPTH - PRETRIG) begin
        m_active = 0;
        m_done   = 1;
      end
    end
    edges++;
  endtask

  task automatic check_outputs();
    check("state", 64'(bus.state_o), 64'(m_state()));
    check("done", 64'(bus.done_o), 64'(m_done));
    check("start_addr", 64'(bus.start_addr_o), 64'(m_start));
    if (p2_v) check("rd_dat", 64'(bus.rd_dat_o), 64'(p2_d));
`ifdef RITC_CAPTURE_TIMESTAMP_EN
    check("ts", 64'(bus.ts_o), 64'(m_ts));
`endif
  endtask

  task automatic tick();
    @(posedge SYSCLK);
    model_update();
    #1;
    check_outputs();
  endtask

  task automatic set_k();
    bus.dat_i = {6{48'(n_wr)}};
  endtask

  function automatic logic [287:0] rnd288();
    logic [287:0] r;
    for (int i = 0; i < 9; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic check_reset_values(input string tag);
    check({tag, "_state"}, 64'(bus.state_o), 64'd0);
    check({tag, "_done"}, 64'(bus.done_o), 64'd0);
    check({tag, "_start"}, 64'(bus.start_addr_o), 64'd0);
    check({tag, "_rd_dat"}, 64'(bus.rd_dat_o), 64'd0);
`ifdef RITC_CAPTURE_TIMESTAMP_EN
    check({tag, "_ts"}, 64'(bus.ts_o), 64'd0);
`endif
  endtask

  task automatic async_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_reset_values(tag);
    repeat (3) @(posedge SYSCLK);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic rd_lit(input string name, input int a, input int ch, input logic [47:0] exp);
    bus.rd_addr_i = ADDR_W'(a);
    bus.rd_ch_i   = 3'(ch);
    tick();
    tick();
    check(name, 64'(bus.rd_dat_o), 64'(exp));
  endtask

  task automatic pulse_arm();
    bus.arm_i = 1'b1;
    tick();
    bus.arm_i = 1'b0;
  endtask

  task automatic wait_done_k(input string name, input int budget, output int cnt);
    cnt = 0;
    while (!bus.done_o && cnt < budget) begin
      set_k();
      tick();
      cnt++;
    end
    check(name, 64'(bus.done_o), 64'd1);
  endtask

  task automatic rand_reads(input int n);
    for (int i = 0; i < n; i++) begin
      bus.rd_addr_i = ADDR_W'($urandom);
      bus.rd_ch_i   = 3'($urandom_range(0, 7));
      bus.valid_i   = 1'($urandom);
      bus.dat_i     = rnd288();
      tick();
    end
  endtask

  initial begin
    int cnt;
    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b0;
    bus.dat_i = '0; bus.valid_i = 0; bus.arm_i = 0; bus.trig_i = 0;
    bus.rd_addr_i = '0; bus.rd_ch_i = '0;
    model_reset();
    #1;
    check_reset_values("por");
    repeat (3) @(posedge SYSCLK);
    #3;
    rst_n = 1'b1;

    // ---- Capture 1: counter words, trig at k=100 ----
    pulse_arm();
    bus.valid_i = 1'b1;
    for (int i = 0; i < 64; i++) begin set_k(); tick(); end
    check("armed_after_64", 64'(bus.state_o), 64'd2);
    for (int i = 0; i < 36; i++) begin set_k(); tick(); end
    set_k(); bus.trig_i = 1'b1; tick(); bus.trig_i = 1'b0;
    check("cap1_start", 64'(bus.start_addr_o), 64'd36);
    wait_done_k("cap1_done", 600, cnt);
    check("cap1_post_cycles", 64'(cnt), 64'd447);
    check("cap1_nwr", 64'(n_wr), 64'd548);
    $display("capture 1 start_addr=%0d done", bus.start_addr_o);
    rd_lit("rd_oldest", 0, 0, 48'd36);
    rd_lit("rd_trigword", 64, 0, 48'd100);
    rd_lit("rd_newest_ch5", 511, 5, 48'd547);
    rd_lit("rd_ch6_zero", 100, 6, 48'd0);
    for (int i = 0; i <= 512; i++) begin
      bus.rd_addr_i = ADDR_W'(i);
      bus.rd_ch_i   = 3'(i % 6);
      tick();
      if (i >= 1) check("rd_sweep", 64'(bus.rd_dat_o), 64'(36 + i - 1));
    end

    // ---- Capture 2: trig in FILL ignored, then tptr wraps below PRETRIG ----
    pulse_arm();
    for (int i = 0; i < 9; i++) begin set_k(); tick(); end
    set_k(); bus.trig_i = 1'b1; tick(); bus.trig_i = 1'b0;
    check("fill_trig_state", 64'(bus.state_o), 64'd1);
    check("fill_trig_done", 64'(bus.done_o), 64'd0);
    for (int i = 0; i < 54; i++) begin set_k(); tick(); end
    check("cap2_armed", 64'(bus.state_o), 64'd2);
    for (int i = 0; i < 422; i++) begin set_k(); tick(); end
    set_k(); bus.trig_i = 1'b1; tick(); bus.trig_i = 1'b0;
    check("cap2_start_wrap", 64'(bus.start_addr_o), 64'd458);
    wait_done_k("cap2_done", 600, cnt);
    $display("capture 2 start_addr=%0d done", bus.start_addr_o);
    rd_lit("cap2_trigword", 64, 3, 48'd1034);
    rand_reads(40);

    // ---- Capture 3: random data, valid toggling in POST ----
    pulse_arm();
    cnt = 0;
    while (bus.state_o != 2'd2 && cnt < 1000) begin
      bus.valid_i = ($urandom_range(0, 3) != 0);
      bus.dat_i = rnd288();
      tick();
      cnt++;
    end
    check("cap3_reach_armed", 64'(bus.state_o), 64'd2);
    for (int i = 0; i < int'($urandom_range(0, 300)); i++) begin
      bus.valid_i = 1'($urandom); bus.dat_i = rnd288(); tick();
    end
    bus.valid_i = 1'b1; bus.dat_i = rnd288(); bus.trig_i = 1'b1; tick(); bus.trig_i = 1'b0;
    cnt = 1;
    for (int c = 0; c < 1200 && !bus.done_o; c++) begin
      bus.valid_i = c[0];
      bus.dat_i = rnd288();
      if (bus.valid_i) cnt++;
      tick();
    end
    check("cap3_done", 64'(bus.done_o), 64'd1);
    check("cap3_post_valid_writes", 64'(cnt), 64'd448);
    $display("capture 3 start_addr=%0d done", bus.start_addr_o);
    rand_reads(300);

    // ---- Random arm/trig pulses, including arm+trig together ----
    for (int i = 0; i < 4000; i++) begin
      bus.arm_i     = ($urandom_range(0, 199) == 0);
      bus.trig_i    = ($urandom_range(0, 49) == 0);
      bus.valid_i   = ($urandom_range(0, 4) != 0);
      bus.dat_i     = rnd288();
      bus.rd_addr_i = ADDR_W'($urandom);
      bus.rd_ch_i   = 3'($urandom_range(0, 7));
      tick();
    end
    bus.arm_i = 1'b0; bus.trig_i = 1'b0;
    $display("random phase done_o=%0d state_o=%0d", bus.done_o, bus.state_o);

    // ---- Reset during POST, then fresh capture ----
    if (bus.state_o != 2'd0) begin
      // let any capture left by the random phase finish or be aborted below
      tick();
    end
    pulse_arm();
    bus.valid_i = 1'b1;
    cnt = 0;
    while (bus.state_o != 2'd2 && cnt < 200) begin set_k(); tick(); cnt++; end
    set_k(); bus.trig_i = 1'b1; tick(); bus.trig_i = 1'b0;
    for (int i = 0; i < 20; i++) begin set_k(); tick(); end
    check("pre_reset_post", 64'(bus.state_o), 64'd3);
    async_reset("midpost");

    pulse_arm();
    bus.valid_i = 1'b1;
    while (edges < 1000) begin set_k(); tick(); end
    set_k(); bus.trig_i = 1'b1; tick(); bus.trig_i = 1'b0;
    check("cap4_start", 64'(bus.start_addr_o), 64'd423);
`ifdef RITC_CAPTURE_TIMESTAMP_EN
    check("cap4_ts", 64'(bus.ts_o), 64'd1000);
`endif
    wait_done_k("cap4_done", 600, cnt);
    $display("capture 4 start_addr=%0d done", bus.start_addr_o);
    rd_lit("cap4_trigword", 64, 2, 48'd999);
    rd_lit("cap4_oldest", 0, 1, 48'd935);
    rand_reads(200);
`ifdef RITC_CAPTURE_TIMESTAMP_EN
    check("cap4_ts_hold", 64'(bus.ts_o), 64'd1000);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
